rr_arbiter8: RTL
================

Name: rr_arbiter8

Overview:
8-requester round-robin arbiter that shares a single downstream resource (shared gate/ALU evaluation port) between up to eight clients. It grants one requester at a time and holds the grant until that requester releases. A bounded hold timeout prevents starvation, and priority rotates past the most recent winner. It sits between the requester bank and the shared datapath and drives its one-hot select.

Parameters:
N_REQ, 8, number of requesters; fixed at 8 (matches 8-way any-request reduction)
MAX_HOLD, 16, max consecutive grant cycles per tenure; 0 disables timeout
HOLD_W, 5, hold counter width; must satisfy 2^HOLD_W > MAX_HOLD

Ports:
clock  input  1  single clock; all state updates on rising edge
reset_n  input  1  asynchronous, active-low reset
req  input  8  per-requester request level; bit i = requester i
grant  output  8  one-hot grant, registered; all-zero when idle
grant_id  output  3  binary index of granted requester; valid only when grant_valid=1
grant_valid  output  1  registered; 1 iff grant != 0
timeout  output  1  registered one-cycle pulse when a grant is revoked by MAX_HOLD
any_req  output  1  combinational OR of req[7:0]

Behaviour:
- Reset (reset_n=0, asynchronous, no clock needed): grant=0, grant_id=0, grant_valid=0, timeout=0, state=IDLE, pointer=0, hold_cnt=0. On deassertion the first edge evaluates from IDLE.
- States: IDLE, BUSY. pointer (3b) = highest-priority index for the next arbitration.
- IDLE: if any_req=1 at an edge, grant the first set req bit searching pointer, pointer+1, ..., 7, 0, ..., pointer-1 (mod 8). Load grant/grant_id and set grant_valid=1 and hold_cnt=1, then go to BUSY. Latency: req sampled at edge k gives grant visible after edge k. If no req, stay IDLE with outputs 0.
- BUSY, release: req[grant_id]=0 at an edge. At that edge grant=0, grant_valid=0, pointer=(grant_id+1) mod 8, go to IDLE. This gives exactly one grant-free turnaround cycle before any new grant.
- BUSY, timeout: MAX_HOLD!=0, hold_cnt==MAX_HOLD, and req[grant_id]=1 at an edge. Revoke the grant exactly as for release and assert timeout=1 for that one cycle. Grant is therefore high for at most MAX_HOLD cycles. A revoked requester that keeps req high stays eligible, but the pointer has moved past it.
- BUSY otherwise: hold grant and increment hold_cnt; saturate at MAX_HOLD.
- Release and timeout condition at the same edge: release takes precedence and timeout stays 0.
- Changes on non-granted req bits during BUSY are ignored until the next IDLE arbitration.
- timeout is 0 in every cycle except the single cycle after a timeout revoke.
- Wrap-around: pointer 7+1 = 0; the search wraps modulo 8.
- Invariants: grant is one-hot or zero; grant_valid == |grant; grant_id == encode(grant) whenever grant_valid=1.
- Reset mid-grant: outputs clear immediately, pointer returns to 0, any pending tenure is discarded.

Decomposition:
- Shared package arb_pkg: N_REQ=8, ID_W=3, state encoding {IDLE=0, BUSY=1}, next-index wrap helper.
- Sub-module rr_pick8, purely combinational: inputs req[7:0] and pointer[2:0]; outputs onehot[7:0], id[2:0], found. Implemented as rotate, fixed-priority pick, un-rotate. found is driven by the existing 8-way OR gate over req; the same instance also drives any_req.
- Top level holds state, pointer, hold_cnt and the registered outputs.

Test Plan:
- Reset: reset_n=0 with req=8'hFF for 3 edges -> grant=0, grant_valid=0, timeout=0. Then reset_n=1 -> first edge grants id 0 (grant=8'h01).
- Single requester: req=8'h08 at edge k -> grant=8'h08, grant_id=3 after edge k. Drop req at edge k+3 -> grant=0 after k+3, pointer=4.
- Rotation (MAX_HOLD=0): req=8'h81 held, each winner releases after 2 cycles then re-raises its req. Grant order is 0, 7, 0, 7, with exactly one idle cycle between tenures.
- Timeout (MAX_HOLD=4): req=8'h04 held high -> grant=8'h04 for exactly 4 cycles, then timeout=1 for 1 cycle with grant=0. Id 2 is regranted on the next edge.
- Precedence (MAX_HOLD=4): the granted requester drops req exactly on the 4th-cycle edge -> grant released, timeout remains 0.
- Async reset mid-grant: while grant=8'h20, pulse reset_n low between edges -> grant=0 immediately. After reset, req=8'h21 -> grant id 0 (pointer reset to 0).

Source files
------------

// File: rtl/arb_pkg.sv
// Shared definitions for the 8-way round-robin arbiter.
package arb_pkg;

    localparam int unsigned N_REQ = 8;
    localparam int unsigned ID_W  = 3;

    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StBusy = 1'b1
    } arb_state_e;

    // Next requester index; the 3-bit add wraps 7 -> 0 naturally.
    function automatic logic [ID_W-1:0] next_idx(input logic [ID_W-1:0] idx);
        return idx + 1'b1;
    endfunction

endpackage

// File: rtl/rr_pick8.sv
// Combinational rotating-priority picker: first set req bit at or after pointer.
module rr_pick8
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  pointer,
    output logic [N_REQ-1:0] onehot,
    output logic [ID_W-1:0]  id,
    output logic             found
);

    logic [2*N_REQ-1:0] req_dbl;
    logic [N_REQ-1:0]   req_rot;
    logic [ID_W-1:0]    offset;

    // The 8-way OR doubles as the "anything to grant" flag.
    assign found = |req;

    // Rotate so pointer lands at bit 0, pick lowest set bit, then un-rotate.
    always_comb begin
        req_dbl = {req, req} >> pointer;
        req_rot = req_dbl[N_REQ-1:0];
        offset  = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                offset = ID_W'(i);
            end
        end
        // Modulo-8 add undoes the rotation.
        id     = pointer + offset;
        onehot = '0;
        if (found) begin
            onehot[id] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_arbiter8.sv
// 8-requester round-robin arbiter with grant hold until release and bounded tenure.
module rr_arbiter8
    import arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned HOLD_W   = 5
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  grant_id,
    output logic             grant_valid,
    output logic             timeout,
    output logic             any_req
);

    // With the timeout disabled the counter just parks at all-ones.
    localparam logic [HOLD_W-1:0] HoldLim = HOLD_W'(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HoldSat = (MAX_HOLD == 0) ? {HOLD_W{1'b1}} : HoldLim;

    arb_state_e        state_q, state_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [N_REQ-1:0]  grant_q, grant_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic              valid_q, valid_d;
    logic              timeout_q, timeout_d;

    logic [N_REQ-1:0]  pick_onehot;
    logic [ID_W-1:0]   pick_id;
    logic              pick_found;
    logic              owner_req;
    logic              hold_hit;

    rr_pick8 u_pick (
        .req     (req),
        .pointer (ptr_q),
        .onehot  (pick_onehot),
        .id      (pick_id),
        .found   (pick_found)
    );

    assign owner_req = req[id_q];
    assign hold_hit  = (MAX_HOLD != 0) && (hold_q == HoldLim);

    // Next-state: arbitrate in idle; release or revoke in busy.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        grant_d   = grant_q;
        id_d      = id_q;
        valid_d   = valid_q;
        timeout_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (pick_found) begin
                    grant_d = pick_onehot;
                    id_d    = pick_id;
                    valid_d = 1'b1;
                    hold_d  = HOLD_W'(1);
                    state_d = StBusy;
                end
            end
            StBusy: begin
                // Release wins over timeout: timeout only flags a still-requesting owner.
                if (!owner_req || hold_hit) begin
                    grant_d   = '0;
                    valid_d   = 1'b0;
                    ptr_d     = next_idx(id_q);
                    state_d   = StIdle;
                    timeout_d = owner_req;
                end else if (hold_q != HoldSat) begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and registered outputs, cleared asynchronously.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            ptr_q     <= '0;
            hold_q    <= '0;
            grant_q   <= '0;
            id_q      <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            grant_q   <= grant_d;
            id_q      <= id_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
        end
    end

    assign grant       = grant_q;
    assign grant_id    = id_q;
    assign grant_valid = valid_q;
    assign timeout     = timeout_q;
    assign any_req     = pick_found;

endmodule
